// File: rtl/ysyx_22040931_lsu_pkg.sv
// Shared types and encodings for the load/store unit and its helpers.
package ysyx_22040931_lsu_pkg;

  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;
  localparam logic [1:0] SizeD = 2'd3;

  typedef enum logic [1:0] {
    LsuIdle = 2'd0,
    LsuReq  = 2'd1,
    LsuWait = 2'd2,
    LsuDone = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_22040931_lsu_strb.sv
// Byte-strobe and natural-alignment check for a sized access within a doubleword.
module ysyx_22040931_lsu_strb
  import ysyx_22040931_lsu_pkg::*;
(
  input  logic [1:0] size,
  input  logic [2:0] addr_lo,
  output logic [7:0] wstrb,
  output logic       misalign
);

  always_comb begin
    wstrb    = 8'h00;
    misalign = 1'b0;
    case (size)
      SizeB: begin
        wstrb = 8'h01 << addr_lo;
      end
      SizeH: begin
        wstrb    = 8'h03 << {addr_lo[2:1], 1'b0};
        misalign = addr_lo[0];
      end
      SizeW: begin
        wstrb    = 8'h0f << {addr_lo[2], 2'b00};
        misalign = |addr_lo[1:0];
      end
      default: begin
        wstrb    = 8'hff;
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040931_lsu.sv
// Load/store unit: one bus transaction per MEM-stage access, stalling the pipe until done.
module ysyx_22040931_lsu
  import ysyx_22040931_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_ena,
  input  logic                  mem_wr,
  input  logic [1:0]            memop,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_stor_data,
  output logic                  stall,
  output logic                  lsu_done,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_misalign,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [ADDR_W-1:0]     req_addr,
  output logic [DATA_W-1:0]     req_wdata,
  output logic [DATA_W/8-1:0]   req_wstrb,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_W-1:0]     rsp_rdata
);

  lsu_state_e state_q, state_d;

  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic                mis_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [7:0] strb;
  logic       mis;
  logic       accept;

  ysyx_22040931_lsu_strb u_strb (
    .size     (memop),
    .addr_lo  (mem_addr[2:0]),
    .wstrb    (strb),
    .misalign (mis)
  );

  assign accept = (state_q == LsuIdle) && mem_ena;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LsuIdle: if (mem_ena)   state_d = mis ? LsuDone : LsuReq;
      LsuReq:  if (req_ready) state_d = LsuWait;
      LsuWait: if (rsp_valid) state_d = LsuDone;
      // mem_ena here still belongs to the retiring access, so never re-accept.
      default: state_d = LsuIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LsuIdle;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= mem_wr;
        addr_q  <= mem_addr;
        wdata_q <= mem_stor_data;
        strb_q  <= mem_wr ? strb : '0;
        mis_q   <= mis;
      end
      if ((state_q == LsuWait) && rsp_valid && !wr_q) begin
        rdata_q <= rsp_rdata >> {addr_q[2:0], 3'b000};
      end
    end
  end

  always_comb begin
    stall        = accept || (state_q == LsuReq) || (state_q == LsuWait);
    lsu_done     = (state_q == LsuDone);
    lsu_misalign = (state_q == LsuDone) && mis_q;
    lsu_rdata    = rdata_q;
    req_valid    = (state_q == LsuReq);
    req_we       = wr_q;
    req_addr     = {addr_q[ADDR_W-1:3], 3'b000};
    req_wdata    = wdata_q;
    req_wstrb    = strb_q;
    rsp_ready    = (state_q == LsuWait);
  end

endmodule

// File: tb/tb_ysyx_22040931_lsu.sv
// Randomized bench for the LSU: the bench acts as bus slave and predicts per-cycle behaviour.
module tb_ysyx_22040931_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ena;
  logic        mem_wr;
  logic [1:0]  memop;
  logic [63:0] mem_addr;
  logic [63:0] mem_stor_data;
  logic        stall;
  logic        lsu_done;
  logic [63:0] lsu_rdata;
  logic        lsu_misalign;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] last_rdata = 64'h0;

  always #5 clk = ~clk;

  ysyx_22040931_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_ena       (mem_ena),
    .mem_wr        (mem_wr),
    .memop         (memop),
    .mem_addr      (mem_addr),
    .mem_stor_data (mem_stor_data),
    .stall         (stall),
    .lsu_done      (lsu_done),
    .lsu_rdata     (lsu_rdata),
    .lsu_misalign  (lsu_misalign),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access from accept to its done cycle; slave inserts dreq/drsp wait cycles.
  task automatic do_access(input bit wr, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wdata, input int dreq, input int drsp,
                           input logic [63:0] rdata);
    int          nbytes, off, done_at, rq, rs;
    bit          mis;
    logic [7:0]  exp_strb;
    logic [63:0] exp_rdata;
    nbytes   = 1 << sz;
    off      = int'(addr[2:0]);
    mis      = (off % nbytes) != 0;
    done_at  = mis ? 1 : 3 + dreq + drsp;
    exp_strb = wr ? 8'(((1 << nbytes) - 1) << off) : 8'h00;
    exp_rdata = (wr || mis) ? last_rdata : (rdata >> (8 * off));
    rq = 0;
    rs = 0;
    for (int c = 0; c <= done_at; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        mem_ena       = 1'b1;
        mem_wr        = wr;
        memop         = sz;
        mem_addr      = addr;
        mem_stor_data = wdata;
      end
      req_ready = req_valid && (rq >= dreq);
      if (req_valid && !req_ready) rq++;
      rsp_valid = rsp_ready && (rs >= drsp);
      rsp_rdata = rdata;
      if (rsp_ready && !rsp_valid) rs++;
      #1;
      check_eq("stall", stall, c < done_at);
      check_eq("lsu_done", lsu_done, c == done_at);
      check_eq("req_valid", req_valid, !mis && c >= 1 && c <= 1 + dreq);
      check_eq("rsp_ready", rsp_ready, !mis && c >= 2 + dreq && c <= 2 + dreq + drsp);
      if (c == 1 && !mis) begin
        check_eq("req_addr", req_addr, {addr[63:3], 3'b000});
        check_eq("req_we", req_we, wr);
        check_eq("req_wstrb", req_wstrb, exp_strb);
        if (wr) check_eq("req_wdata", req_wdata, wdata);
      end
      if (c == done_at) begin
        check_eq("lsu_misalign", lsu_misalign, mis);
        check_eq("lsu_rdata", lsu_rdata, exp_rdata);
      end
    end
    last_rdata = exp_rdata;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    mem_ena   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    #1;
    check_eq("idle_stall", stall, 1'b0);
    check_eq("idle_done", lsu_done, 1'b0);
    check_eq("idle_req_valid", req_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] a, d;
    logic [1:0]  sz;
    rst_n = 1'b0;
    mem_ena = 1'b0; mem_wr = 1'b0; memop = 2'd0; mem_addr = '0; mem_stor_data = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_valid", req_valid, 1'b0);
    check_eq("rst_req_we", req_we, 1'b0);
    check_eq("rst_rsp_ready", rsp_ready, 1'b0);
    check_eq("rst_lsu_done", lsu_done, 1'b0);
    check_eq("rst_misalign", lsu_misalign, 1'b0);
    check_eq("rst_req_addr", req_addr, 64'h0);
    check_eq("rst_req_wdata", req_wdata, 64'h0);
    check_eq("rst_req_wstrb", req_wstrb, 8'h00);
    check_eq("rst_lsu_rdata", lsu_rdata, 64'h0);
    rst_n = 1'b1;
    idle_cycle();

    // Directed cases
    do_access(1'b0, 2'd3, 64'h8000_0008, 64'h0, 1, 1, 64'h1122_3344_5566_7788);
    do_access(1'b0, 2'd0, 64'h8000_0005, 64'h0, 0, 0, 64'h1122_3344_5566_7788);
    do_access(1'b1, 2'd1, 64'h8000_0006, 64'hbeef_0000_0000_0000, 0, 0, 64'hdead_0000_dead_0000);
    do_access(1'b0, 2'd2, 64'h8000_0002, 64'h0, 0, 0, 64'hffff_ffff_ffff_ffff);
    do_access(1'b1, 2'd3, 64'h8000_0010, 64'h0123_4567_89ab_cdef, 0, 0, 64'h0);
    do_access(1'b1, 2'd2, 64'h8000_0014, 64'hcafe_f00d_0000_0000, 0, 0, 64'h0);
    idle_cycle();

    // Random traffic, mostly aligned, with random gaps and slave waits
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fff8)};
      a[2:0] = 3'($urandom);
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      d  = {$urandom, $urandom};
      do_access(1'($urandom), sz, a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // Reset while in WAIT with a response presented
    do_access(1'b0, 2'd3, 64'h8000_0040, 64'h0, 0, 0, 64'h5a5a_a5a5_1234_5678);
    @(posedge clk); #1;
    mem_ena = 1'b1; mem_wr = 1'b0; memop = 2'd3; mem_addr = 64'h8000_0048;
    req_ready = 1'b0; rsp_valid = 1'b0;
    @(posedge clk); #1;
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 64'h0bad_0bad_0bad_0bad;
    rst_n = 1'b0;
    #1;
    check_eq("pre_rst_rsp_ready", rsp_ready, 1'b1);
    @(posedge clk); #1;
    mem_ena = 1'b0;
    rsp_valid = 1'b0;
    #1;
    check_eq("post_rst_req_valid", req_valid, 1'b0);
    check_eq("post_rst_rsp_ready", rsp_ready, 1'b0);
    check_eq("post_rst_lsu_done", lsu_done, 1'b0);
    check_eq("post_rst_lsu_rdata", lsu_rdata, 64'h0);
    check_eq("post_rst_stall", stall, 1'b0);
    rst_n = 1'b1;
    last_rdata = 64'h0;
    idle_cycle();
    do_access(1'b0, 2'd1, 64'h8000_0102, 64'h0, 2, 1, 64'h0123_4567_89ab_cdef);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
